trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
Sequences machine-mode trap entry and MRET return around the machine CSR file. Collects synchronous exceptions (pipeline and CSR-access faults) and pending interrupts, and arbitrates them by fixed priority. Drives the CSR file's trap_taken/trap_done update strobes and next-value buses. Owns the current privilege level and issues the PC redirect/flush to the fetch stage.

Parameters:
XLEN, 64, data/address width
RESET_PRIV, 2'b11, privilege level after reset (M)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
pc_addr  in  XLEN  PC of the instruction in the commit stage
instr_valid  in  1  commit-stage instruction valid
exc_req  in  1  pipeline synchronous exception request
exc_req_code  in  4  pipeline exception cause
exc_req_val  in  XLEN  pipeline exception tval
csr_exc_en  in  1  CSR-file access fault (illegal instruction)
csr_exc_val  in  XLEN  CSR-file fault tval
mret_req  in  1  MRET at commit
mstatus_current  in  XLEN  live mstatus from the CSR file
mtvec  in  XLEN  live mtvec
mepc  in  XLEN  live mepc
mie  in  XLEN  interrupt enable
mip  in  XLEN  interrupt pending
trap_taken  out  1  CSR update strobe, trap entry
trap_done  out  1  CSR update strobe, MRET
mepc_next  out  XLEN  value for mepc
mcause_next  out  XLEN  value for mcause
mtval_next  out  XLEN  value for mtval
mstatus_next  out  XLEN  value for mstatus
priv_lvl  out  2  current privilege (0=U, 3=M)
pc_redirect  out  1  one-cycle redirect pulse
pc_target  out  XLEN  redirect target
flush  out  1  one-cycle pipeline flush
busy  out  1  high in every state except IDLE; stalls commit

Behaviour:
- Reset (async, rst=1): state=IDLE, priv_lvl=RESET_PRIV, all other outputs 0, latched cause/tval/epc registers 0.
- States: IDLE, ENTER, RETURN, REDIRECT.
- Event detection happens in IDLE only; inputs are ignored while busy=1.
- Priority, highest first:
  1. csr_exc_en (cause 2, tval=csr_exc_val)
  2. exc_req (cause=exc_req_code, tval=exc_req_val)
  3. mret_req
  4. interrupt
- mret_req is honoured only when priv_lvl==3. Otherwise it is treated as an illegal-instruction exception: cause 2, tval 0.
- Interrupt is pending when (mip & mie) is non-zero and (priv_lvl<3 or mstatus_current[3]==1).
  - Interrupt priority: MEI(11) > MSI(3) > MTI(7).
  - mcause_next = {1'b1, zeros, code}; tval=0.
- Synchronous exceptions require instr_valid=1. Interrupts do not.
- On capture of any trap or MRET: latch epc=pc_addr, cause, tval; pulse flush; go to ENTER (trap) or RETURN (MRET). busy rises in the next cycle.
- ENTER (1 cycle): trap_taken=1, mepc_next=epc with bits[1:0] cleared, mcause_next, mtval_next.
  - mstatus_next = mstatus_current with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=priv_lvl.
  - priv_lvl becomes 3 at the end of the cycle.
- RETURN (1 cycle): trap_done=1.
  - mstatus_next: MIE=MPIE, MPIE=1, MPP=00.
  - priv_lvl becomes the MPP value; MPP=2'b10 (unsupported S) maps to 0.
  - mepc_next, mcause_next and mtval_next echo the live mepc, the latched cause and the latched tval, so the CSR file keeps its values.
- REDIRECT (1 cycle): pc_redirect=1, then return to IDLE.
  - After ENTER: pc_target = {mtvec[XLEN-1:2],2'b00}.
  - After RETURN: pc_target = mepc.
- Latency: capture cycle N, strobe N+1, redirect N+2, IDLE N+3.
- Outside their states, trap_taken, trap_done, pc_redirect and flush are 0 and the next-value buses hold 0.
- Reset asserted mid-sequence aborts immediately to the reset values. No strobe is emitted after rst deasserts.

Optional Feature:
VECTORED_IRQ_EN
- Defined: when mtvec[1:0]==01 and the trap is an interrupt, pc_target = base + 4*code. Exceptions always go to base.
- Undefined: mtvec[1:0] is ignored and all traps go to base.

Test Plan:
- Reset: rst=1 mid-ENTER → all outputs 0, priv_lvl=3 within 0 cycles; after release, no trap_taken.
- Illegal CSR: priv=0, csr_exc_en=1, csr_exc_val=0x300, pc=0x1000, mtvec=0x8000 → N+1 trap_taken, mcause_next=2, mtval_next=0x300, mepc_next=0x1000, MPP=00; N+2 pc_target=0x8000; priv_lvl=3.
- Simultaneous csr_exc_en and exc_req code 3 → mcause_next=2; exc_req is dropped.
- MRET: priv=3, mstatus MPIE=1, MPP=00, mepc=0x2004 → trap_done, mstatus_next MIE=1, MPIE=1, MPP=0; pc_target=0x2004; priv_lvl=0.
- Timer IRQ: mip[7]=mie[7]=1, MIE=1, priv=3 → mcause_next=0x8000000000000007; with VECTORED_IRQ_EN and mtvec=0x8001, pc_target=0x801C, otherwise 0x8000.
- Masked IRQ: MIE=0, priv=3, mip[11]=mie[11]=1 → no trap; drop priv to 0 via MRET → trap taken in the next IDLE cycle, cause 11.

Source files
------------

// File: rtl/trap_controller.sv
// Machine-mode trap entry / MRET sequencer: arbitrates events in IDLE and drives CSR strobes, privilege and redirect.
// Latency: capture N (flush), CSR strobe N+1, pc_redirect N+2, back in IDLE N+3.
// No backpressure: busy stalls commit and inputs are ignored. VECTORED_IRQ_EN enables vectored interrupt targets.
module trap_controller #(
  parameter int         XLEN       = 64,
  parameter logic [1:0] RESET_PRIV = 2'b11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_addr,
  input  logic            instr_valid,
  input  logic            exc_req,
  input  logic [3:0]      exc_req_code,
  input  logic [XLEN-1:0] exc_req_val,
  input  logic            csr_exc_en,
  input  logic [XLEN-1:0] csr_exc_val,
  input  logic            mret_req,
  input  logic [XLEN-1:0] mstatus_current,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mip,
  output logic            trap_taken,
  output logic            trap_done,
  output logic [XLEN-1:0] mepc_next,
  output logic [XLEN-1:0] mcause_next,
  output logic [XLEN-1:0] mtval_next,
  output logic [XLEN-1:0] mstatus_next,
  output logic [1:0]      priv_lvl,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target,
  output logic            flush,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ENTER, RETURN, REDIRECT} state_t;

  state_t          state, state_nxt;
  logic [1:0]      priv_q;
  logic [XLEN-1:0] epc_q, cause_q, tval_q;
  logic            is_irq_q, from_ret_q;

  logic [XLEN-1:0] irq_pend;
  logic [3:0]      irq_code;
  logic            irq_ok;
  logic            take_trap, take_mret, irq_d;
  logic [XLEN-1:0] cause_d, tval_d;
  logic [1:0]      ret_priv;
  logic [XLEN-1:0] tvec_base, vec_target;
  logic            unused_bits;

  // Only the three machine-level interrupt sources are arbitrated.
  always_comb begin
    irq_pend  = mip & mie;
    irq_code  = irq_pend[11] ? 4'd11 : (irq_pend[3] ? 4'd3 : 4'd7);
    irq_ok    = (irq_pend[11] | irq_pend[3] | irq_pend[7]) &&
                ((priv_q != 2'b11) || mstatus_current[3]);
    take_trap = 1'b0;
    take_mret = 1'b0;
    irq_d     = 1'b0;
    cause_d   = '0;
    tval_d    = '0;
    if (state == IDLE && !rst) begin
      if (instr_valid && csr_exc_en) begin
        take_trap = 1'b1;
        cause_d   = XLEN'(2);
        tval_d    = csr_exc_val;
      end else if (instr_valid && exc_req) begin
        take_trap = 1'b1;
        cause_d   = {{(XLEN-4){1'b0}}, exc_req_code};
        tval_d    = exc_req_val;
      end else if (instr_valid && mret_req) begin
        if (priv_q == 2'b11) begin
          take_mret = 1'b1;
        end else begin
          take_trap = 1'b1;
          cause_d   = XLEN'(2);
        end
      end else if (irq_ok) begin
        take_trap = 1'b1;
        irq_d     = 1'b1;
        cause_d   = {1'b1, {(XLEN-5){1'b0}}, irq_code};
      end
    end
  end

  assign ret_priv  = (mstatus_current[12:11] == 2'b10) ? 2'b00 : mstatus_current[12:11];
  assign tvec_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef VECTORED_IRQ_EN
  assign vec_target = (is_irq_q && mtvec[1:0] == 2'b01) ?
                      tvec_base + {cause_q[XLEN-3:0], 2'b00} : tvec_base;
`else
  assign vec_target = tvec_base;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      priv_q     <= RESET_PRIV;
      epc_q      <= '0;
      cause_q    <= '0;
      tval_q     <= '0;
      is_irq_q   <= 1'b0;
      from_ret_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // MRET keeps cause/tval so the echoed values leave the CSR file unchanged.
      if (take_trap) begin
        epc_q      <= pc_addr;
        cause_q    <= cause_d;
        tval_q     <= tval_d;
        is_irq_q   <= irq_d;
        from_ret_q <= 1'b0;
      end else if (take_mret) begin
        epc_q      <= pc_addr;
        is_irq_q   <= 1'b0;
        from_ret_q <= 1'b1;
      end
      if (state == ENTER) begin
        priv_q <= 2'b11;
      end else if (state == RETURN) begin
        priv_q <= ret_priv;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    trap_taken   = 1'b0;
    trap_done    = 1'b0;
    pc_redirect  = 1'b0;
    mepc_next    = '0;
    mcause_next  = '0;
    mtval_next   = '0;
    mstatus_next = '0;
    pc_target    = '0;
    case (state)
      IDLE: begin
        if (take_trap)      state_nxt = ENTER;
        else if (take_mret) state_nxt = RETURN;
      end
      ENTER: begin
        trap_taken           = 1'b1;
        mepc_next            = {epc_q[XLEN-1:2], 2'b00};
        mcause_next          = cause_q;
        mtval_next           = tval_q;
        mstatus_next         = mstatus_current;
        mstatus_next[7]      = mstatus_current[3];
        mstatus_next[3]      = 1'b0;
        mstatus_next[12:11]  = priv_q;
        state_nxt            = REDIRECT;
      end
      RETURN: begin
        trap_done            = 1'b1;
        mepc_next            = mepc;
        mcause_next          = cause_q;
        mtval_next           = tval_q;
        mstatus_next         = mstatus_current;
        mstatus_next[3]      = mstatus_current[7];
        mstatus_next[7]      = 1'b1;
        mstatus_next[12:11]  = 2'b00;
        state_nxt            = REDIRECT;
      end
      REDIRECT: begin
        pc_redirect = 1'b1;
        pc_target   = from_ret_q ? mepc : vec_target;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign flush    = take_trap | take_mret;
  assign busy     = (state != IDLE);
  assign priv_lvl = priv_q;

  assign unused_bits = ^{mtvec[1:0], irq_pend, epc_q[1:0], is_irq_q};

endmodule

// File: tb/tb_trap_controller.sv
// Randomized + directed bench for trap_controller against a transaction-level expectation queue.
module tb_trap_controller;

  logic        clk, rst;
  logic [63:0] pc_addr, exc_req_val, csr_exc_val, mstatus_current, mtvec, mepc, mie, mip;
  logic        instr_valid, exc_req, csr_exc_en, mret_req;
  logic [3:0]  exc_req_code;
  logic        trap_taken, trap_done, pc_redirect, flush, busy;
  logic [63:0] mepc_next, mcause_next, mtval_next, mstatus_next, pc_target;
  logic [1:0]  priv_lvl;

  trap_controller #(.XLEN(64), .RESET_PRIV(2'b11)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .instr_valid(instr_valid),
    .exc_req(exc_req), .exc_req_code(exc_req_code), .exc_req_val(exc_req_val),
    .csr_exc_en(csr_exc_en), .csr_exc_val(csr_exc_val), .mret_req(mret_req),
    .mstatus_current(mstatus_current), .mtvec(mtvec), .mepc(mepc), .mie(mie), .mip(mip),
    .trap_taken(trap_taken), .trap_done(trap_done), .mepc_next(mepc_next),
    .mcause_next(mcause_next), .mtval_next(mtval_next), .mstatus_next(mstatus_next),
    .priv_lvl(priv_lvl), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tt, td, red;
    logic [1:0]  pv;
    logic [63:0] mepc_n, mcause_n, mtval_n, mstatus_n, tgt;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  m_priv;
  logic [63:0] m_cause, m_tval;
  logic [63:0] obs_mepc, obs_mcause, obs_mtval, obs_mstatus, obs_target;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t blank(input logic [1:0] pv);
    exp_t e;
    e.tt = 0; e.td = 0; e.red = 0; e.pv = pv;
    e.mepc_n = 0; e.mcause_n = 0; e.mtval_n = 0; e.mstatus_n = 0; e.tgt = 0;
    return e;
  endfunction

  // One clock cycle: inputs already driven; check mid-cycle, then advance to the next negedge.
  task automatic step();
    exp_t        e;
    logic        ev_trap, ev_mret, ev_irq;
    logic [63:0] c, t, code, pend, ms, base;
    logic [1:0]  np;
    #1;
    if (trap_taken || trap_done) begin
      obs_mepc = mepc_next; obs_mcause = mcause_next; obs_mtval = mtval_next; obs_mstatus = mstatus_next;
    end
    if (pc_redirect) obs_target = pc_target;
    if (exp_q.size() == 0) begin
      ev_trap = 0; ev_mret = 0; ev_irq = 0; c = 0; t = 0; code = 0;
      pend = mip & mie;
      if (instr_valid && csr_exc_en) begin
        ev_trap = 1; c = 2; t = csr_exc_val;
      end else if (instr_valid && exc_req) begin
        ev_trap = 1; c = {60'd0, exc_req_code}; t = exc_req_val;
      end else if (instr_valid && mret_req) begin
        if (m_priv == 2'd3) ev_mret = 1;
        else begin ev_trap = 1; c = 2; t = 0; end
      end else if ((pend[11] || pend[3] || pend[7]) && (m_priv != 2'd3 || mstatus_current[3])) begin
        ev_trap = 1; ev_irq = 1;
        if (pend[11]) code = 11; else if (pend[3]) code = 3; else code = 7;
        c = 64'h8000_0000_0000_0000 | code;
      end
      chk("idle_busy", busy, 0);
      chk("idle_flush", flush, ev_trap | ev_mret);
      chk("idle_strobes", {trap_taken, trap_done, pc_redirect}, 0);
      chk("idle_buses", mcause_next | mepc_next | mstatus_next | pc_target, 0);
      chk("idle_priv", priv_lvl, m_priv);
      if (ev_trap) begin
        ms = mstatus_current;
        ms[7] = mstatus_current[3]; ms[3] = 0; ms[12:11] = m_priv;
        e = blank(m_priv);
        e.tt = 1; e.mepc_n = pc_addr & ~64'h3; e.mcause_n = c; e.mtval_n = t; e.mstatus_n = ms;
        exp_q.push_back(e);
        base = mtvec & ~64'h3;
`ifdef VECTORED_IRQ_EN
        if (ev_irq && mtvec[1:0] == 2'b01) base = base + code * 4;
`endif
        e = blank(2'd3);
        e.red = 1; e.tgt = base;
        exp_q.push_back(e);
        m_priv = 2'd3; m_cause = c; m_tval = t;
      end else if (ev_mret) begin
        ms = mstatus_current;
        ms[3] = mstatus_current[7]; ms[7] = 1; ms[12:11] = 0;
        np = (mstatus_current[12:11] == 2'b10) ? 2'b00 : mstatus_current[12:11];
        e = blank(m_priv);
        e.td = 1; e.mepc_n = mepc; e.mcause_n = m_cause; e.mtval_n = m_tval; e.mstatus_n = ms;
        exp_q.push_back(e);
        e = blank(np);
        e.red = 1; e.tgt = mepc;
        exp_q.push_back(e);
        m_priv = np;
      end
    end else begin
      e = exp_q.pop_front();
      chk("busy", busy, 1);
      chk("flush", flush, 0);
      chk("trap_taken", trap_taken, e.tt);
      chk("trap_done", trap_done, e.td);
      chk("pc_redirect", pc_redirect, e.red);
      chk("priv", priv_lvl, e.pv);
      chk("mepc_next", mepc_next, e.mepc_n);
      chk("mcause_next", mcause_next, e.mcause_n);
      chk("mtval_next", mtval_next, e.mtval_n);
      chk("mstatus_next", mstatus_next, e.mstatus_n);
      chk("pc_target", pc_target, e.tgt);
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    instr_valid = 0; exc_req = 0; csr_exc_en = 0; mret_req = 0;
    exc_req_code = 0; exc_req_val = 0; csr_exc_val = 0; mip = 0; mie = 0;
  endtask

  task automatic clr_obs();
    obs_mepc = 0; obs_mcause = 0; obs_mtval = 0; obs_mstatus = 0; obs_target = 0;
  endtask

  task automatic rand_events();
    instr_valid  = ($urandom_range(0, 3) != 0);
    csr_exc_en   = ($urandom_range(0, 9) == 0);
    exc_req      = ($urandom_range(0, 7) == 0);
    mret_req     = ($urandom_range(0, 4) == 0);
    exc_req_code = 4'($urandom);
    exc_req_val  = {$urandom, $urandom};
    csr_exc_val  = {$urandom, $urandom};
    pc_addr      = {$urandom, $urandom};
    mip = 0; mie = 0;
    mip[3]  = ($urandom_range(0, 5) == 0); mie[3]  = ($urandom_range(0, 1) == 0);
    mip[7]  = ($urandom_range(0, 5) == 0); mie[7]  = ($urandom_range(0, 1) == 0);
    mip[11] = ($urandom_range(0, 5) == 0); mie[11] = ($urandom_range(0, 1) == 0);
  endtask

  task automatic rand_csrs();
    mstatus_current = {$urandom, $urandom};
    mtvec = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 0) mtvec[1:0] = 2'b01;
    mepc = {$urandom, $urandom};
  endtask

  initial begin
    clk = 0; rst = 1;
    quiet();
    pc_addr = 0; mstatus_current = 0; mtvec = 0; mepc = 0;
    m_priv = 2'd3; m_cause = 0; m_tval = 0;
    clr_obs();
    #1;
    chk("rst_priv", priv_lvl, 3);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {trap_taken, trap_done, pc_redirect, flush}, 0);
    chk("rst_buses", mcause_next | mepc_next | mtval_next | mstatus_next | pc_target, 0);
    @(negedge clk); rst = 0;
    step();

    // MRET from M with MPIE=1, MPP=U
    clr_obs();
    mstatus_current = 64'h80; mepc = 64'h2004; pc_addr = 64'h1234;
    instr_valid = 1; mret_req = 1;
    step(); quiet(); step(); step();
    chk("mret_mie", obs_mstatus[3], 1);
    chk("mret_mpie", obs_mstatus[7], 1);
    chk("mret_mpp", obs_mstatus[12:11], 0);
    chk("mret_target", obs_target, 64'h2004);
    chk("mret_priv", priv_lvl, 0);

    // Illegal CSR access from U
    clr_obs();
    mstatus_current = 0; mtvec = 64'h8000; pc_addr = 64'h1000;
    instr_valid = 1; csr_exc_en = 1; csr_exc_val = 64'h300;
    step(); quiet(); step(); step();
    chk("csr_mcause", obs_mcause, 2);
    chk("csr_mtval", obs_mtval, 64'h300);
    chk("csr_mepc", obs_mepc, 64'h1000);
    chk("csr_mpp", obs_mstatus[12:11], 0);
    chk("csr_target", obs_target, 64'h8000);
    chk("csr_priv", priv_lvl, 3);

    // CSR fault wins over a simultaneous pipeline exception
    clr_obs();
    instr_valid = 1; csr_exc_en = 1; exc_req = 1; exc_req_code = 4'd3; exc_req_val = 64'h55;
    step(); quiet(); step(); step(); step();
    chk("simul_mcause", obs_mcause, 2);

    // Timer interrupt, possibly vectored
    clr_obs();
    mstatus_current = 64'h8; mtvec = 64'h8001; mip[7] = 1; mie[7] = 1;
    step(); quiet(); step(); step();
    chk("tmr_mcause", obs_mcause, 64'h8000_0000_0000_0007);
`ifdef VECTORED_IRQ_EN
    chk("tmr_target", obs_target, 64'h801C);
`else
    chk("tmr_target", obs_target, 64'h8000);
`endif

    // Masked external interrupt, unmasked by dropping to U via MRET
    clr_obs();
    mstatus_current = 0; mtvec = 64'h8000; mepc = 64'h3000; mip[11] = 1; mie[11] = 1;
    step();
    chk("masked_busy", busy, 0);
    instr_valid = 1; mret_req = 1;
    step(); instr_valid = 0; mret_req = 0;
    step(); step(); step(); quiet(); step(); step();
    chk("unmask_mcause", obs_mcause, 64'h8000_0000_0000_000B);

    // Reset in the middle of ENTER
    instr_valid = 1; exc_req = 1; exc_req_code = 4'd5; exc_req_val = 64'h77;
    step();
    rst = 1;
    #1;
    chk("mid_rst_strobes", {trap_taken, trap_done, pc_redirect, flush, busy}, 0);
    chk("mid_rst_buses", mcause_next | mepc_next | mtval_next | mstatus_next | pc_target, 0);
    chk("mid_rst_priv", priv_lvl, 3);
    exp_q.delete(); m_priv = 2'd3; m_cause = 0; m_tval = 0;
    @(negedge clk); rst = 0; quiet();
    step(); step(); step();

    repeat (1500) begin
      if (exp_q.size() == 0) rand_csrs();
      rand_events();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
